// File: rtl/i2s_tx_serializer.sv
// I2S (Philips) transmit serializer.
// Samples BCLK/LRCLK in the SAICLK domain and shifts stereo sample pairs out on DOUT,
// MSB first, one BCLK after each word-select change.
module i2s_tx_serializer #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned SLOT_W = 32
) (
    input  logic              SAICLK,
    input  logic              reset,
    input  logic              BCLK,
    input  logic              LRCLK,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              s_ready,
    output logic              DOUT,
    output logic              frame_sync,
    output logic              underrun,
    output logic              frame_err
);

    localparam int unsigned       CNT_W    = $clog2(SLOT_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SLOT_W);

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               bclk_q;
    logic               lr_q;
    logic               tick;
    logic               ws_chg;
    logic               accept;
    logic               load_left;
    logic               load_right;
    logic               shift_en;
    logic               buf_full;
    logic               buf_full_nxt;
    logic [DATA_W-1:0]  buf_left;
    logic [DATA_W-1:0]  buf_right;
    logic [DATA_W-1:0]  right_hold;
    logic [SLOT_W-1:0]  shreg;
    logic [SLOT_W-1:0]  load_word;
    logic [CNT_W-1:0]   bit_cnt;

    assign tick         = BCLK & ~bclk_q;
    assign ws_chg       = tick & (LRCLK != lr_q);
    assign accept       = s_valid & s_ready;
    assign buf_full_nxt = accept | (buf_full & ~load_left);

    // BCLK edge detect and word-select history
    always_ff @(posedge SAICLK) begin
        if (reset) begin
            bclk_q <= 1'b0;
            lr_q   <= 1'b0;
        end else begin
            bclk_q <= BCLK;
            if (tick) begin
                lr_q <= LRCLK;
            end
        end
    end

    // FSM state register
    always_ff @(posedge SAICLK) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: leave SYNC on the first left-slot start
    always_comb begin
        state_nxt = state;
        if (state == SYNC && ws_chg && !LRCLK) begin
            state_nxt = RUN;
        end
    end

    // FSM outputs: slot loads and shift enable
    always_comb begin
        load_left  = 1'b0;
        load_right = 1'b0;
        shift_en   = 1'b0;
        case (state)
            SYNC: begin
                load_left = ws_chg & ~LRCLK;
            end
            RUN: begin
                load_left  = ws_chg & ~LRCLK;
                load_right = ws_chg & LRCLK;
                shift_en   = tick & ~ws_chg;
            end
        endcase
    end

    // Slot word: sample left-aligned, zero padded; empty buffer yields silence
    always_comb begin
        load_word = '0;
        if (load_left) begin
            if (buf_full) begin
                load_word[SLOT_W-1 -: DATA_W] = buf_left;
            end
        end else begin
            load_word[SLOT_W-1 -: DATA_W] = right_hold;
        end
    end

    // Shift register, DOUT and bit counter
    always_ff @(posedge SAICLK) begin
        if (reset) begin
            DOUT    <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load_left || load_right) begin
            DOUT    <= load_word[SLOT_W-1];
            shreg   <= {load_word[SLOT_W-2:0], 1'b0};
            bit_cnt <= CNT_W'(1);
        end else if (shift_en) begin
            DOUT  <= shreg[SLOT_W-1];
            shreg <= {shreg[SLOT_W-2:0], 1'b0};
            if (bit_cnt != CNT_FULL) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // Holding buffer; an accept coincident with an empty left load is kept for the next frame
    always_ff @(posedge SAICLK) begin
        if (reset) begin
            buf_full   <= 1'b0;
            s_ready    <= 1'b0;
            buf_left   <= '0;
            buf_right  <= '0;
            right_hold <= '0;
        end else begin
            buf_full <= buf_full_nxt;
            s_ready  <= ~buf_full_nxt;
            if (load_left) begin
                right_hold <= buf_full ? buf_right : '0;
            end
            if (accept) begin
                buf_left  <= s_left;
                buf_right <= s_right;
            end
        end
    end

    // Status pulses, one cycle after the causing tick
    always_ff @(posedge SAICLK) begin
        if (reset) begin
            frame_sync <= 1'b0;
            underrun   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_sync <= load_left;
            underrun   <= load_left & ~buf_full;
            frame_err  <= (state == RUN) & ws_chg & (bit_cnt != CNT_FULL);
        end
    end

endmodule
